scramble_sequencer: RTL
=======================

# scramble_sequencer

Move initiator for the 4x4 cell grid. On a start pulse it drives a burst of pseudo-random row or column moves, each with a one-cycle `fire`, into the cells' `row_en`/`col_en`/`fire` interface. When idle it passes the debounced user move through unchanged. It sits between the user input conditioning (`row_col_input`, `generic_debounce`) and the 16 cell instances, and replaces the free-running always-scramble path.

## Interface
- `NUM_MOVES`, 16: number of moves per scramble burst, 1..255.
- `GAP_CYCLES`, 16: fire-to-fire period in clocks, >= 2.
- `LFSR_SEED`, 8'hA5: LFSR reset value, must be nonzero.

- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle request to begin a scramble burst.
- `user_fire` in 1: debounced user fire.
- `user_row_col` in 4: one-hot user row/column select.
- `user_nRow` in 1: 0 = row move, 1 = column move.
- `user_error` in 1: high when the user select is not one-hot.
- `row` out 4: one-hot row enable to the cells.
- `col` out 4: one-hot column enable to the cells.
- `fire` out 1: move strobe to the cells.
- `busy` out 1: high while a burst is in progress.
- `done` out 1: one-cycle pulse when a burst ends.
- `moves_left` out 8: moves remaining in the current burst.

## Operation
- State machine with states IDLE, ISSUE, GAP and DONE. Reset enters IDLE.
- An 8-bit Galois LFSR uses polynomial x^8+x^6+x^5+x^4+1. It advances every clock, in every state.
- The candidate move is `lfsr[2:0]`:
  - bit2 selects the axis: 0 = row, 1 = column.
  - bits[1:0] select the index: 00 → 4'b0001, 01 → 4'b0010, 10 → 4'b0100, 11 → 4'b1000.
- IDLE:
  - Outputs are combinational passthrough: `fire = user_fire`.
  - If `user_error`: `row = col = 0`.
  - Otherwise the one-hot select goes to `row` when `user_nRow = 0`, or to `col` when `user_nRow = 1`. The other output is 0.
  - On `start`: load `moves_left = NUM_MOVES`, go to ISSUE.
- ISSUE:
  - Register the candidate onto `row`/`col` and assert `fire` for this one cycle.
  - Decrement `moves_left`.
  - If the decremented value is 0, go to DONE. Otherwise go to GAP.
- GAP:
  - `fire = 0`. `row`/`col` hold the last move.
  - Count `GAP_CYCLES - 1` clocks, then go to ISSUE.
- DONE:
  - `done = 1` for one cycle and `row = col = 0`.
  - Next state is IDLE.
- `busy = 1` in ISSUE and GAP.
- In ISSUE, GAP and DONE, all user inputs and `start` are ignored.

## Timing
- Reset values: `row = 0`, `col = 0`, `fire = 0`, `busy = 0`, `done = 0`, `moves_left = 0`, LFSR = `LFSR_SEED`, state = IDLE.
- In IDLE the passthrough is zero-latency (combinational).
- Burst timing, with `start` sampled high at edge N:
  - First `fire` is high in cycle N+1.
  - Subsequent fires follow every `GAP_CYCLES` clocks.
  - The last fire is in cycle N+1+(NUM_MOVES-1)·GAP_CYCLES.
  - `done` is high the following cycle, and `busy` is low in that cycle.
- `moves_left` shows the decremented value from the cycle after each fire.
- `NUM_MOVES = 1` gives ISSUE → DONE with no GAP.
- `start` and `user_fire` asserted in the same IDLE cycle: the passthrough `fire` occurs in that cycle and the burst starts next cycle.
- Asserting `reset_n` low mid-burst immediately forces all outputs to their reset values. No partial move is completed.

## Configuration
- `SCRAMBLE_NO_REPEAT_EN` defined: in ISSUE, a candidate equal to the previously issued move (same axis and index) is rejected.
  - On rejection: `fire = 0`, the state stays ISSUE, `moves_left` is unchanged, and a fresh candidate is evaluated next cycle.
  - The period after a rejection stretches by 1 cycle per rejection.
  - The previous-move register clears at reset and at `start`.
- Not defined: every candidate is issued. Repeats are allowed and timing is exact as above.

## Structure
- Shared package `scramble_pkg` holds:
  - the state encoding localparams (IDLE = 2'd0, ISSUE = 2'd1, GAP = 2'd2, DONE = 2'd3);
  - the LFSR tap mask 8'hB8;
  - the one-hot decode function for index → 4-bit select.
- One sub-module, `lfsr8`, with ports `clk`, `reset_n`, `seed`, `q[7:0]`. It is free-running.
- The sequencer FSM, gap counter and output mux live in `scramble_sequencer`.

## Test plan
- Idle passthrough: `user_row_col = 4'b0100`, `user_nRow = 0`, `user_fire = 1` → `row = 4'b0100`, `col = 0`, `fire = 1` in the same cycle. With `user_error = 1` → `row = col = 0`.
- Burst with `NUM_MOVES = 4`, `GAP_CYCLES = 4`, `start` at cycle 0:
  - `fire` high in cycles 1, 5, 9, 13 and low elsewhere;
  - `moves_left` reads 3, 2, 1, 0 after each fire;
  - `done` high in cycle 14 only;
  - every move has exactly one bit set, in exactly one of `row`/`col`.
- Bursts ignore inputs: `start` pulses and `user_fire = 1` at cycle 3 of a burst → fire schedule unchanged, no second burst.
- Reset mid-burst: `reset_n` low at cycle 7 → all outputs 0 immediately. After release, the first LFSR value equals `LFSR_SEED` and the FSM is in IDLE.
- With `SCRAMBLE_NO_REPEAT_EN`: `NUM_MOVES = 64` → no two consecutive fired moves are identical, total fires = 64, and each fire-to-fire interval is ≥ `GAP_CYCLES`.
- `NUM_MOVES = 1` → exactly one `fire` at cycle 1 and `done` at cycle 2.

Source files
------------

// File: rtl/scramble_pkg.sv
// Shared definitions for the scramble sequencer slice.
//   state_t     : sequencer FSM states (IDLE/ISSUE/GAP/DONE, 2-bit encoding)
//   LFSR_TAPS   : Galois tap mask for x^8+x^6+x^5+x^4+1 (right-shifting form)
//   onehot4()   : 2-bit index -> 4-bit one-hot select
//   lfsr_next() : one Galois LFSR step
package scramble_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    onehot4 = 4'b0001 << idx;
  endfunction

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    lfsr_next = (v >> 1) ^ (v[0] ? LFSR_TAPS : 8'h00);
  endfunction

endpackage

// File: rtl/scramble_sequencer_lfsr8.sv
// Free-running 8-bit Galois LFSR; advances every clock.
//   clk     : system clock
//   reset_n : asynchronous active-low reset, loads seed
//   seed    : reset value (must be nonzero; tie to a constant)
//   q       : current LFSR state
module lfsr8
  import scramble_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] seed,
  output logic [7:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) q <= seed;
    else          q <= lfsr_next(q);
  end

endmodule

// File: rtl/scramble_sequencer.sv
// Move initiator for the 4x4 cell grid. On start, issues NUM_MOVES
// pseudo-random row/column moves, one fire every GAP_CYCLES clocks;
// when idle, passes the debounced user move straight through.
//   clk, reset_n       : clock, asynchronous active-low reset
//   start              : single-cycle burst request (honoured only in IDLE)
//   user_fire          : debounced user strobe
//   user_row_col       : one-hot user select
//   user_nRow          : 0 = row move, 1 = column move
//   user_error         : user select is not one-hot
//   row, col, fire     : cell interface (one-hot enables + strobe)
//   busy               : burst in progress (ISSUE/GAP)
//   done               : one-cycle pulse at burst end
//   moves_left         : moves remaining in the current burst
// Optional build macro SCRAMBLE_NO_REPEAT_EN: reject a candidate equal to
// the previously issued move (stay in ISSUE, try the next LFSR value).
module scramble_sequencer
  import scramble_pkg::*;
#(
  parameter int unsigned NUM_MOVES  = 16,
  parameter int unsigned GAP_CYCLES = 16,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       user_fire,
  input  logic [3:0] user_row_col,
  input  logic       user_nRow,
  input  logic       user_error,
  output logic [3:0] row,
  output logic [3:0] col,
  output logic       fire,
  output logic       busy,
  output logic       done,
  output logic [7:0] moves_left
);

  // Gap counter holds GAP_CYCLES-2 down to 0 (GAP_CYCLES-1 GAP clocks).
  localparam int unsigned GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES - 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 2);

  state_t           state_q, state_d;
  logic [7:0]       lfsr;
  logic [4:0]       lfsr_unused;
  logic [7:0]       moves_q;
  logic [GAP_W-1:0] gap_q;
  logic [3:0]       last_row_q, last_col_q;
  logic [3:0]       cand_sel, issue_row, issue_col;
  logic             accept;

  lfsr8 u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .seed    (LFSR_SEED),
    .q       (lfsr)
  );

  assign lfsr_unused = lfsr[7:3];
  assign cand_sel    = onehot4(lfsr[1:0]);
  assign issue_row   = lfsr[2] ? '0 : cand_sel;
  assign issue_col   = lfsr[2] ? cand_sel : '0;
  assign moves_left  = moves_q;

`ifdef SCRAMBLE_NO_REPEAT_EN
  logic       prev_valid_q;
  logic [2:0] prev_mv_q;
  assign accept = !(prev_valid_q && (prev_mv_q == lfsr[2:0]));
`else
  assign accept = 1'b1;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ISSUE;
      ISSUE:   if (accept) state_d = (moves_q == 8'd1) ? DONE : GAP;
      GAP:     if (gap_q == '0) state_d = ISSUE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Burst datapath: move counter, gap counter, held move
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      moves_q    <= '0;
      gap_q      <= '0;
      last_row_q <= '0;
      last_col_q <= '0;
`ifdef SCRAMBLE_NO_REPEAT_EN
      prev_valid_q <= 1'b0;
      prev_mv_q    <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            moves_q <= 8'(NUM_MOVES);
`ifdef SCRAMBLE_NO_REPEAT_EN
            prev_valid_q <= 1'b0;
`endif
          end
        end
        ISSUE: begin
          if (accept) begin
            moves_q    <= moves_q - 8'd1;
            gap_q      <= GAP_LOAD;
            last_row_q <= issue_row;
            last_col_q <= issue_col;
`ifdef SCRAMBLE_NO_REPEAT_EN
            prev_valid_q <= 1'b1;
            prev_mv_q    <= lfsr[2:0];
`endif
          end
        end
        GAP: begin
          if (gap_q != '0) gap_q <= gap_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Output mux. The ISSUE move is decoded straight from the registered LFSR
  // so it lines up with fire; last_*_q then holds it through GAP. Outputs
  // are gated by reset_n so an asserted reset zeroes them even in IDLE.
  always_comb begin
    row  = '0;
    col  = '0;
    fire = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    if (reset_n) begin
      case (state_q)
        IDLE: begin
          fire = user_fire;
          if (!user_error) begin
            if (user_nRow) col = user_row_col;
            else           row = user_row_col;
          end
        end
        ISSUE: begin
          busy = 1'b1;
          if (accept) begin
            fire = 1'b1;
            row  = issue_row;
            col  = issue_col;
          end else begin
            row  = last_row_q;
            col  = last_col_q;
          end
        end
        GAP: begin
          busy = 1'b1;
          row  = last_row_q;
          col  = last_col_q;
        end
        DONE: done = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
